// File: rtl/sword_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sword_disp_pkg
//  Description : Shared definitions for the SWORD front-panel display driver.
//                Holds the 7-segment hex decode function, the serial frame
//                lengths and the frame sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sword_disp_pkg;

    localparam int SEG_BITS = 64;   // 8 digits x 8 segment bits
    localparam int LED_BITS = 16;   // 16 discrete LEDs

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Active-high {g,f,e,d,c,b,a} pattern for a hex digit
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sword_board_display_if.sv
`default_nettype none
// ============================================================================
//  Interface   : sword_board_display_if
//  Description : Display content inputs and the two serial chain outputs.
//                master : the SoC side that supplies content
//                slave  : the display driver
//  Signals     : en[7:0], data[31:0], dot[7:0], led[15:0]  (content)
//                seg_clk/do/en/clr_n, led_clk/do/en/clr_n (chain drive)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sword_board_display_if;
    logic [7:0]  en;
    logic [31:0] data;
    logic [7:0]  dot;
    logic [15:0] led;
    logic        seg_clk;
    logic        seg_do;
    logic        seg_en;
    logic        seg_clr_n;
    logic        led_clk;
    logic        led_do;
    logic        led_en;
    logic        led_clr_n;

    modport master (
        output en, data, dot, led,
        input  seg_clk, seg_do, seg_en, seg_clr_n,
        input  led_clk, led_do, led_en, led_clr_n
    );

    modport slave (
        input  en, data, dot, led,
        output seg_clk, seg_do, seg_en, seg_clr_n,
        output led_clk, led_do, led_en, led_clr_n
    );
endinterface
`default_nettype wire

// File: rtl/sword_board_display_hex7seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex7seg
//  Description : Builds one active-low {dp,g,f,e,d,c,b,a} segment byte.
//                A disabled digit is fully blank (all ones).
//  Ports       : nibble_i[3:0] hex value, dot_i decimal point (1 = lit),
//                en_i digit enable, seg_o[7:0] active-low segment byte
//  Revision    : 1.0 - initial release
// ============================================================================
module hex7seg
    import sword_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dot_i,
    input  logic       en_i,
    output logic [7:0] seg_o
);

    assign seg_o = en_i ? ~{dot_i, hex7(nibble_i)} : 8'hFF;

endmodule
`default_nettype wire

// File: rtl/sword_board_display.sv
`default_nettype none
// ============================================================================
//  Module      : sword_board_display
//  Description : Continuous serial refresh of the SWORD front panel: eight
//                7-segment digits (64-bit chain) and 16 LEDs (16-bit chain).
//                Frame = LOAD (1 clk) -> SHIFT (128*DIV clk) -> HOLD (HOLD clk).
//  Parameters  : DIV  - clk cycles per half shift-clock period (>= 1)
//                HOLD - display-enabled idle cycles between frames (>= 1)
//  Ports       : clk, rstn (async, active-low), disp (slave modport)
//  Revision    : 1.0 - initial release
// ============================================================================
module sword_board_display
    import sword_disp_pkg::*;
#(
    parameter int DIV  = 2,
    parameter int HOLD = 1024
) (
    input  logic                        clk,
    input  logic                        rstn,
    sword_board_display_if.slave        disp
);

    localparam int BCW = $clog2(SEG_BITS);
    localparam int DW  = (DIV  > 1) ? $clog2(DIV)  : 1;
    localparam int HW  = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [DW-1:0]  DIV_LAST  = DW'(DIV - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(SEG_BITS - 1);
    localparam logic [BCW-1:0] LED_END   = BCW'(LED_BITS);

    logic [SEG_BITS-1:0] seg_frame;

    for (genvar i = 0; i < 8; i++) begin : g_digit
        hex7seg u_hex7seg (
            .nibble_i (disp.data[4*i +: 4]),
            .dot_i    (disp.dot[i]),
            .en_i     (disp.en[i]),
            .seg_o    (seg_frame[8*i +: 8])
        );
    end

    state_e              state_q,    state_d;
    logic [SEG_BITS-1:0] seg_sr_q,   seg_sr_d;
    logic [LED_BITS-1:0] led_sr_q,   led_sr_d;
    logic [BCW-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DW-1:0]       div_cnt_q,  div_cnt_d;
    logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
    logic                phase_q,    phase_d;     // 0 = low half, 1 = high half
    logic                seg_clk_q,  seg_clk_d;
    logic                seg_do_q,   seg_do_d;
    logic                led_clk_q,  led_clk_d;
    logic                led_do_q,   led_do_d;
    logic                en_q,       en_d;        // shared by both chains
    logic                clr_n_q,    clr_n_d;
    logic                led_active;

    // The LED chain only rides along with the first 16 segment bits
    assign led_active = (bit_cnt_q < LED_END);

    always_comb begin
        state_d    = state_q;
        seg_sr_d   = seg_sr_q;
        led_sr_d   = led_sr_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        hold_cnt_d = hold_cnt_q;
        phase_d    = phase_q;
        seg_clk_d  = seg_clk_q;
        seg_do_d   = seg_do_q;
        led_clk_d  = led_clk_q;
        led_do_d   = led_do_q;
        en_d       = en_q;
        clr_n_d    = 1'b1;

        case (state_q)
            ST_LOAD: begin
                seg_sr_d   = seg_frame;
                led_sr_d   = ~disp.led;
                bit_cnt_d  = '0;
                div_cnt_d  = '0;
                hold_cnt_d = '0;
                phase_d    = 1'b0;
                seg_clk_d  = 1'b0;
                led_clk_d  = 1'b0;
                en_d       = 1'b0;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Outputs for the slot described by the counters this cycle
                seg_do_d  = seg_sr_q[SEG_BITS-1];
                seg_clk_d = phase_q;
                en_d      = 1'b0;
                if (led_active) begin
                    led_do_d  = led_sr_q[LED_BITS-1];
                    led_clk_d = phase_q;
                end else begin
                    led_clk_d = 1'b0;
                end
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    phase_d   = ~phase_q;
                    if (phase_q) begin
                        // End of the high half: advance to the next bit
                        seg_sr_d  = {seg_sr_q[SEG_BITS-2:0], 1'b0};
                        if (led_active) begin
                            led_sr_d = {led_sr_q[LED_BITS-2:0], 1'b0};
                        end
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = ST_HOLD;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                seg_clk_d = 1'b0;
                led_clk_d = 1'b0;
                en_d      = 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_LOAD;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_LOAD;
            seg_sr_q   <= '0;
            led_sr_q   <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            hold_cnt_q <= '0;
            phase_q    <= 1'b0;
            seg_clk_q  <= 1'b0;
            seg_do_q   <= 1'b0;
            led_clk_q  <= 1'b0;
            led_do_q   <= 1'b0;
            en_q       <= 1'b0;
            clr_n_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_sr_q   <= seg_sr_d;
            led_sr_q   <= led_sr_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            phase_q    <= phase_d;
            seg_clk_q  <= seg_clk_d;
            seg_do_q   <= seg_do_d;
            led_clk_q  <= led_clk_d;
            led_do_q   <= led_do_d;
            en_q       <= en_d;
            clr_n_q    <= clr_n_d;
        end
    end

    assign disp.seg_clk   = seg_clk_q;
    assign disp.seg_do    = seg_do_q;
    assign disp.seg_en    = en_q;
    assign disp.seg_clr_n = clr_n_q;
    assign disp.led_clk   = led_clk_q;
    assign disp.led_do    = led_do_q;
    assign disp.led_en    = en_q;
    assign disp.led_clr_n = clr_n_q;

endmodule
`default_nettype wire

// File: tb/tb_sword_board_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sword_board_display
//  Description : Self-checking bench. DUT0 (DIV=2) walks a table of content
//                vectors, changing inputs mid-SHIFT; DUT1 (DIV=3) holds fixed
//                content. A monitor rebuilds each serial frame from the
//                shift-clock rising edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sword_board_display;

    localparam int HOLD_T = 20;
    localparam int DIV0   = 2;
    localparam int DIV1   = 3;
    localparam int NVEC   = 5;

    typedef struct {
        logic [7:0]  en;
        logic [31:0] data;
        logic [7:0]  dot;
        logic [15:0] led;
        logic [63:0] exp_seg;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs [NVEC];

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sword_board_display_if if0 ();
    sword_board_display_if if1 ();

    sword_board_display #(.DIV(DIV0), .HOLD(HOLD_T)) u_dut0 (
        .clk  (clk),
        .rstn (rstn),
        .disp (if0)
    );

    sword_board_display #(.DIV(DIV1), .HOLD(HOLD_T)) u_dut1 (
        .clk  (clk),
        .rstn (rstn),
        .disp (if1)
    );

    // bit 7 seg_clk, 6 seg_do, 5 seg_en, 4 seg_clr_n, 3 led_clk, 2 led_do, 1 led_en, 0 led_clr_n
    logic [7:0] outs [2];
    assign outs[0] = {if0.seg_clk, if0.seg_do, if0.seg_en, if0.seg_clr_n,
                      if0.led_clk, if0.led_do, if0.led_en, if0.led_clr_n};
    assign outs[1] = {if1.seg_clk, if1.seg_do, if1.seg_en, if1.seg_clr_n,
                      if1.led_clk, if1.led_do, if1.led_en, if1.led_clr_n};

    int checks = 0;
    int errors = 0;

    // Monitor state (written only by the monitor process, on negedge)
    logic [7:0]  p_out [2];
    logic [63:0] cap [2];
    logic [15:0] lcap [2];
    int scnt [2], lcnt [2], lhigh [2], enrun [2], cyc [2], last_rise [2];
    bit have_rise [2];
    logic [63:0] f_seg [2];
    logic [15:0] f_led [2];
    int f_bits [2], f_lrise [2], f_lhigh [2], f_period [2], f_hold [2], frames [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            p_out[d] = '0; cap[d] = '0; lcap[d] = '0;
            scnt[d] = 0; lcnt[d] = 0; lhigh[d] = 0; enrun[d] = 0; cyc[d] = 0;
            last_rise[d] = 0; have_rise[d] = 0; f_seg[d] = '0; f_led[d] = '0;
            f_bits[d] = 0; f_lrise[d] = 0; f_lhigh[d] = 0; f_period[d] = 0;
            f_hold[d] = 0; frames[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                cyc[d]++;
                if (!rstn) begin
                    scnt[d] = 0; lcnt[d] = 0; lhigh[d] = 0; enrun[d] = 0;
                    have_rise[d] = 0; f_hold[d] = 0; p_out[d] = '0;
                end else begin
                    if (outs[d][7] && !p_out[d][7]) begin
                        cap[d] = {cap[d][62:0], outs[d][6]};
                        scnt[d]++;
                    end
                    if (outs[d][3] && !p_out[d][3]) begin
                        lcap[d] = {lcap[d][14:0], outs[d][2]};
                        lcnt[d]++;
                    end
                    if (outs[d][3]) lhigh[d]++;
                    if (outs[d][5] && !p_out[d][5]) begin
                        f_seg[d]    = cap[d];
                        f_bits[d]   = scnt[d];
                        f_led[d]    = lcap[d];
                        f_lrise[d]  = lcnt[d];
                        f_lhigh[d]  = lhigh[d];
                        f_period[d] = have_rise[d] ? (cyc[d] - last_rise[d]) : 0;
                        last_rise[d] = cyc[d];
                        have_rise[d] = 1'b1;
                        scnt[d] = 0; lcnt[d] = 0; lhigh[d] = 0;
                        enrun[d] = 1;
                        frames[d]++;
                    end else if (outs[d][5]) begin
                        enrun[d]++;
                    end
                    if (!outs[d][5] && p_out[d][5]) f_hold[d] = enrun[d];
                    p_out[d] = outs[d];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic apply0(input int vi);
        if0.en   = vecs[vi].en;
        if0.data = vecs[vi].data;
        if0.dot  = vecs[vi].dot;
        if0.led  = vecs[vi].led;
    endtask

    task automatic wait_frame(input int d);
        int start;
        start = frames[d];
        for (int n = 0; n < 3000 && frames[d] == start; n++) tick();
        if (frames[d] == start) timeout($sformatf("d%0d frame", d));
    endtask

    task automatic wait_bits(input int d, input int target);
        for (int n = 0; n < 3000 && scnt[d] < target; n++) tick();
        if (scnt[d] < target) timeout($sformatf("d%0d bits>=%0d", d, target));
    endtask

    task automatic check_frame(input int d, input int vi, input bit first, input int div);
        chk($sformatf("d%0d v%0d seg_frame", d, vi), f_seg[d], vecs[vi].exp_seg);
        chk($sformatf("d%0d v%0d seg_bits", d, vi), 64'(f_bits[d]), 64'd64);
        chk($sformatf("d%0d v%0d led_frame", d, vi), 64'(f_led[d]), 64'(vecs[vi].exp_led));
        chk($sformatf("d%0d v%0d led_rises", d, vi), 64'(f_lrise[d]), 64'd16);
        chk($sformatf("d%0d v%0d led_high_cycles", d, vi), 64'(f_lhigh[d]), 64'(16 * div));
        if (!first) begin
            chk($sformatf("d%0d v%0d period", d, vi), 64'(f_period[d]), 64'(1 + 128 * div + HOLD_T));
            chk($sformatf("d%0d v%0d hold_len", d, vi), 64'(f_hold[d]), 64'(HOLD_T));
        end
    endtask

    initial begin
        //          en     data           dot    led       expected seg frame     expected led
        vecs[0] = '{8'hFF, 32'h01234567, 8'h00, 16'hA5C3, 64'hC0F9A4B0_999282F8, 16'h5A3C};
        vecs[1] = '{8'h0F, 32'h89ABCDEF, 8'h01, 16'h0000, 64'hFFFFFFFF_C6A1860E, 16'hFFFF};
        vecs[2] = '{8'h81, 32'h00000000, 8'hFF, 16'hFFFF, 64'h40FFFFFF_FFFFFF40, 16'h0000};
        vecs[3] = '{8'hFF, 32'hDEADBEEF, 8'h80, 16'h8001, 64'h218688A1_8386868E, 16'h7FFE};
        vecs[4] = '{8'hFF, 32'h89ABCDEF, 8'h00, 16'h1234, 64'h80908883_C6A1868E, 16'hEDCB};

        rstn = 1'b0;
        apply0(0);
        if1.en   = vecs[0].en;
        if1.data = vecs[0].data;
        if1.dot  = vecs[0].dot;
        if1.led  = vecs[0].led;

        repeat (3) tick();
        chk("reset_outputs_d0", 64'(outs[0]), 64'h0);
        chk("reset_outputs_d1", 64'(outs[1]), 64'h0);

        rstn = 1'b1;
        #1;
        chk("clr_n_before_edge", 64'({outs[0][4], outs[0][0]}), 64'h0);
        tick();   // LOAD edge
        chk("clr_n_after_edge", 64'({outs[0][4], outs[0][0]}), 64'h3);
        chk("seg_en_after_load", 64'(outs[0][5]), 64'h0);
        tick();   // first bit presented, shift clock still low
        chk("first_bit_do", 64'(outs[0][6]), 64'(vecs[0].exp_seg[63]));
        chk("first_bit_clk_low", 64'(outs[0][7]), 64'h0);

        // Each frame: new content arrives mid-SHIFT and must only show next frame
        wait_bits(0, 10);
        for (int i = 0; i < NVEC; i++) begin
            if (i < NVEC - 1) apply0(i + 1);
            wait_frame(0);
            check_frame(0, i, (i == 0), DIV0);
            if (i < NVEC - 1) wait_bits(0, 10);
        end

        // Reset in the middle of a frame, then a full fresh frame
        wait_bits(0, 30);
        rstn = 1'b0;
        #1;
        chk("midframe_reset_d0", 64'(outs[0]), 64'h0);
        chk("midframe_reset_d1", 64'(outs[1]), 64'h0);
        repeat (2) tick();
        rstn = 1'b1;
        wait_frame(0);
        check_frame(0, NVEC - 1, 1'b1, DIV0);

        // Slower prescaler instance with fixed content
        wait_frame(1);
        wait_frame(1);
        check_frame(1, 0, 1'b0, DIV1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
